// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with operand forwarding
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [RADDR-1:0] in_rd,
    input  logic [2:0]       in_alu_control,
    input  logic             in_alu_src,
    input  logic             in_reg_write,
    input  logic             flush,
    input  logic             fwd_m_en,
    input  logic             fwd_w_en,
    input  logic [RADDR-1:0] fwd_m_rd,
    input  logic [RADDR-1:0] fwd_w_rd,
    input  logic [XLEN-1:0]  fwd_m_data,
    input  logic [XLEN-1:0]  fwd_w_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  src_a,
    output logic [XLEN-1:0]  src_b,
    output logic [2:0]       alu_control,
    output logic [XLEN-1:0]  store_data,
    output logic [RADDR-1:0] out_rd,
    output logic             out_reg_write,
    output logic [CNTW-1:0]  stall_count
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [XLEN-1:0]  r_rd1, r_rd2, r_imm;
    logic [RADDR-1:0] r_rs1, r_rs2, r_rd;
    logic [2:0]       r_alu;
    logic             r_src, r_rw, r_valid;
    logic [CNTW-1:0]  r_cnt;
    logic             accept;
    logic [XLEN-1:0]  fwd_a, fwd_b;

    // Ready ignores flush so the upstream handshake never depends on the kill path.
    assign in_ready = !r_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Holding register: reset beats flush, flush beats accept, accept beats consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_alu   <= '0;
            r_src   <= 1'b0;
            r_rw    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (accept) begin
            r_valid <= 1'b1;
            r_rd1   <= in_rd1;
            r_rd2   <= in_rd2;
            r_imm   <= in_imm;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_rd    <= in_rd;
            r_alu   <= in_alu_control;
            r_src   <= in_alu_src;
            r_rw    <= in_reg_write;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Back-pressure counter saturates instead of wrapping; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_valid && !out_ready && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Forwarding per operand: memory stage wins over writeback, x0 never forwards.
    always_comb begin
        fwd_a = r_rd1;
        if (fwd_m_en && (fwd_m_rd == r_rs1) && (r_rs1 != '0)) begin
            fwd_a = fwd_m_data;
        end else if (fwd_w_en && (fwd_w_rd == r_rs1) && (r_rs1 != '0)) begin
            fwd_a = fwd_w_data;
        end
        fwd_b = r_rd2;
        if (fwd_m_en && (fwd_m_rd == r_rs2) && (r_rs2 != '0)) begin
            fwd_b = fwd_m_data;
        end else if (fwd_w_en && (fwd_w_rd == r_rs2) && (r_rs2 != '0)) begin
            fwd_b = fwd_w_data;
        end
    end

    assign src_a         = fwd_a;
    assign src_b         = r_src ? r_imm : fwd_b;
    assign store_data    = fwd_b;
    assign alu_control   = r_alu;
    assign out_rd        = r_rd;
    assign out_reg_write = r_rw && r_valid;
    assign out_valid     = r_valid;
    assign stall_count   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_alu_src, in_reg_write, flush;
    logic [31:0] in_rd1, in_rd2, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_alu_control;
    logic        fwd_m_en, fwd_w_en;
    logic [4:0]  fwd_m_rd, fwd_w_rd;
    logic [31:0] fwd_m_data, fwd_w_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_reg_write;
    logic [31:0] src_a, src_b, store_data;
    logic [2:0]  alu_control;
    logic [4:0]  out_rd;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid, s_out_reg_write;
    logic [31:0] s_src_a, s_src_b, s_store_data;
    logic [2:0]  s_alu_control;
    logic [4:0]  s_out_rd;
    logic [3:0]  s_stall_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RADDR(5), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_control(in_alu_control), .in_alu_src(in_alu_src),
        .in_reg_write(in_reg_write), .flush(flush),
        .fwd_m_en(fwd_m_en), .fwd_w_en(fwd_w_en),
        .fwd_m_rd(fwd_m_rd), .fwd_w_rd(fwd_w_rd),
        .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
        .store_data(store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .stall_count(stall_count)
    );

    id_ex_stage #(.XLEN(32), .RADDR(5), .CNTW(4)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_control(in_alu_control), .in_alu_src(in_alu_src),
        .in_reg_write(in_reg_write), .flush(flush),
        .fwd_m_en(fwd_m_en), .fwd_w_en(fwd_w_en),
        .fwd_m_rd(fwd_m_rd), .fwd_w_rd(fwd_w_rd),
        .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .src_a(s_src_a), .src_b(s_src_b), .alu_control(s_alu_control),
        .store_data(s_store_data), .out_rd(s_out_rd),
        .out_reg_write(s_out_reg_write), .stall_count(s_stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [2:0] alu, input logic src, input logic rw);
        in_valid       = 1'b1;
        in_rd1         = rd1;
        in_rd2         = rd2;
        in_imm         = imm;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_rd          = rd;
        in_alu_control = alu;
        in_alu_src     = src;
        in_reg_write   = rw;
    endtask

    task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                              input logic [2:0] alu, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.a = a; e.b = b; e.sd = sd; e.alu = alu; e.rd = rd; e.rw = rw;
        exp_q.push_back(e);
    endtask

    // Monitor: every transfer on the output handshake is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_src_a", src_a, e.a);
                    chk("mon_src_b", src_b, e.b);
                    chk("mon_store_data", store_data, e.sd);
                    chk("mon_alu_control", {29'd0, alu_control}, {29'd0, e.alu});
                    chk("mon_out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("mon_out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_rd1 = '0; in_rd2 = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_alu_control = '0; in_alu_src = 1'b0; in_reg_write = 1'b0;
        fwd_m_en = 1'b0; fwd_w_en = 1'b0; fwd_m_rd = '0; fwd_w_rd = '0;
        fwd_m_data = '0; fwd_w_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
        chk("rst_src_a", src_a, 32'd0);
        chk("rst_src_b", src_b, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        chk("rst_alu_control", {29'd0, alu_control}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single accept, then consume.
        present(32'd5, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 1'b1);
        expect_out(32'd5, 32'd3, 32'd3, 3'b001, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_src_a", src_a, 32'd5);
        chk("t1_src_b", src_b, 32'd3);
        tick();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        chk("t1_rw_forced_low", {31'd0, out_reg_write}, 32'd0);

        // Immediate select, followed back-to-back by a second instruction.
        present(32'd9, 32'd7, 32'hFFFF_FFFC, 5'd5, 5'd6, 5'd7, 3'b010, 1'b1, 1'b0);
        expect_out(32'd9, 32'hFFFF_FFFC, 32'd7, 3'b010, 5'd7, 1'b0);
        tick();
        chk("t2_src_b_imm", src_b, 32'hFFFF_FFFC);
        chk("t2_store_data", store_data, 32'd7);
        present(32'd20, 32'd30, 32'd1, 5'd8, 5'd9, 5'd10, 3'b000, 1'b0, 1'b1);
        expect_out(32'd20, 32'd30, 32'd30, 3'b000, 5'd10, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_b2b_rd", {27'd0, out_rd}, 32'd10);
        tick();

        // Forwarding priority, evaluated while the instruction is held.
        out_ready = 1'b0;
        present(32'h11, 32'h22, 32'd0, 5'd4, 5'd0, 5'd8, 3'b011, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        fwd_m_en = 1'b1; fwd_m_rd = 5'd4; fwd_m_data = 32'hAA;
        fwd_w_en = 1'b1; fwd_w_rd = 5'd4; fwd_w_data = 32'hBB;
        #1;
        chk("t3_fwd_mem", src_a, 32'hAA);
        fwd_m_en = 1'b0;
        #1;
        chk("t3_fwd_wb", src_a, 32'hBB);
        fwd_m_en = 1'b1;
        out_ready = 1'b1;
        expect_out(32'hAA, 32'h22, 32'h22, 3'b011, 5'd8, 1'b1);
        tick();
        fwd_m_rd = 5'd0; fwd_w_rd = 5'd0;
        present(32'h33, 32'h44, 32'd0, 5'd0, 5'd0, 5'd9, 3'b000, 1'b0, 1'b1);
        expect_out(32'h33, 32'h44, 32'h44, 3'b000, 5'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3_x0_no_fwd", src_a, 32'h33);
        tick();
        fwd_m_en = 1'b0; fwd_w_en = 1'b0;

        // Back-pressure for three cycles, then release together with a new input.
        out_ready = 1'b0;
        present(32'h100, 32'h200, 32'd0, 5'd10, 5'd11, 5'd12, 3'b101, 1'b0, 1'b1);
        expect_out(32'h100, 32'h200, 32'h200, 3'b101, 5'd12, 1'b1);
        tick();
        present(32'h300, 32'h400, 32'd0, 5'd13, 5'd14, 5'd15, 3'b001, 1'b0, 1'b0);
        chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick(); tick(); tick();
        chk("t4_stall_count", {16'd0, stall_count}, 32'd3);
        chk("t4_held_src_a", src_a, 32'h100);
        chk("t4_held_rd", {27'd0, out_rd}, 32'd12);
        out_ready = 1'b1;
        #1;
        chk("t4_in_ready_high", {31'd0, in_ready}, 32'd1);
        expect_out(32'h300, 32'h400, 32'h400, 3'b001, 5'd15, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t4_new_accepted", {27'd0, out_rd}, 32'd15);
        tick();
        chk("t4_count_kept", {16'd0, stall_count}, 32'd3);

        // Flush while stalled with a competing input.
        out_ready = 1'b0;
        present(32'h500, 32'h600, 32'd0, 5'd16, 5'd17, 5'd18, 3'b000, 1'b0, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        present(32'h700, 32'h800, 32'd0, 5'd19, 5'd20, 5'd21, 3'b011, 1'b0, 1'b1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_not_captured", {27'd0, out_rd}, 32'd18);
        chk("t5_rw_low", {31'd0, out_reg_write}, 32'd0);
        chk("t5_count_kept", {16'd0, stall_count}, 32'd5);

        // Saturation on the 4-bit counter instance, then reset.
        present(32'h900, 32'hA00, 32'd0, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_sat_count", {28'd0, s_stall_count}, 32'd15);
        chk("t6_wide_count", {16'd0, stall_count}, 32'd25);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_sat_count", {28'd0, s_stall_count}, 32'd0);
        chk("t6_rst_count", {16'd0, stall_count}, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
